// File: rtl/dm_pkg.sv
// dm_pkg: shared state encoding, byte-enable constants and address check for dm_responder
package dm_pkg;
   typedef enum logic [2:0] {INIT, IDLE, WAIT, COMMIT, RESP} state_e;
   localparam logic [3:0] BE_WORD    = 4'b1111;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   // addresses below base are rejected explicitly so wrap-around never aliases into range
   function automatic logic addr_bad(input logic [31:0] addr, input logic [31:0] base, input logic [31:0] depth);
      logic [31:0] off;
      off = addr - base;
      return (addr[1:0] != 2'b00) || (addr < base) || ((off >> 2) >= depth);
   endfunction
endpackage

// File: rtl/dm_ram.sv
// dm_ram: single-port word RAM with per-byte write enables and combinational read
module dm_ram #(
   parameter int DEPTH_WORDS = 1024,
   parameter int ADDR_W      = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [3:0]        be,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);
   logic [31:0] mem_q [DEPTH_WORDS];
   always_ff @(posedge clk)
      for (int i = 0; i < 4; i++)
         if (we && be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
   assign rdata = mem_q[addr];
endmodule

// File: rtl/dm_responder.sv
// dm_responder: valid/ready data-memory responder with INIT clear sweep, wait latency and error check
module dm_responder
   import dm_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          ADDR_W      = 10,
   parameter int          WAIT_CYCLES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [3:0]  req_be,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_pc,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] clr_q, clr_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [31:0]       addr_q, addr_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       pc_q, pc_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              bad;
   logic [ADDR_W-1:0] widx;
   logic              ram_we;
   logic [3:0]        ram_be;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdata, ram_rdata;

   assign bad       = addr_bad(addr_q, BASE_ADDR, 32'(DEPTH_WORDS));
   assign widx      = ADDR_W'((addr_q - BASE_ADDR) >> 2);
   assign req_ready = state_q == IDLE;
   assign rsp_valid = state_q == RESP;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

   always_comb begin
      state_d   = state_q;
      clr_d     = clr_q;
      cnt_d     = cnt_q;
      we_d      = we_q;
      addr_d    = addr_q;
      be_d      = be_q;
      wdata_d   = wdata_q;
      pc_d      = pc_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      ram_we    = 1'b0;
      ram_be    = be_q;
      ram_addr  = widx;
      ram_wdata = wdata_q;
      case (state_q)
         INIT: begin
            ram_we    = 1'b1;
            ram_be    = BE_WORD;
            ram_addr  = clr_q;
            ram_wdata = '0;
            clr_d     = clr_q + 1'b1;
            state_d   = clr_q == ADDR_W'(DEPTH_WORDS - 1) ? IDLE : INIT;
         end
         IDLE: if (req_valid) begin
            we_d    = req_we;
            addr_d  = req_addr;
            be_d    = req_be;
            wdata_d = req_wdata;
            pc_d    = req_pc;
            cnt_d   = 4'(WAIT_CYCLES);
            state_d = WAIT_CYCLES == 0 ? COMMIT : WAIT;
         end
         WAIT: begin
            cnt_d   = cnt_q - 4'd1;
            state_d = cnt_q == 4'd1 ? COMMIT : WAIT;
         end
         COMMIT: begin
            ram_we  = we_q && !bad;
            err_d   = bad;
            rdata_d = (we_q || bad) ? '0 : ram_rdata;
            state_d = RESP;
         end
         RESP: state_d = rsp_ready ? IDLE : RESP;
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q <= INIT;
         clr_q   <= '0;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         pc_q    <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         clr_q   <= clr_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         pc_q    <= pc_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end

   dm_ram #(.DEPTH_WORDS(DEPTH_WORDS), .ADDR_W(ADDR_W)) u_ram (
      .clk  (clk),
      .we   (ram_we),
      .be   (ram_be),
      .addr (ram_addr),
      .wdata(ram_wdata),
      .rdata(ram_rdata)
   );

`ifndef SYNTHESIS
   logic [31:0] be_mask;
   assign be_mask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
   always_ff @(posedge clk)
      if (state_q == COMMIT && we_q && !bad)
         $display("%d@%h: *%h <= %h", $time, pc_q, addr_q, (ram_rdata & ~be_mask) | (wdata_q & be_mask));
`endif
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: random and directed transactions on two responders checked against a word-array model
module tb_dm_responder;
   import dm_pkg::*;
   localparam int DEPTH = 1024;

   logic        clk = 0;
   logic        reset = 1;
   logic        req_valid = 0, req_we = 0, rsp_ready = 0;
   logic [31:0] req_addr = 0, req_wdata = 0, req_pc = 0;
   logic [3:0]  req_be = 0;
   int          sel = 0;
   logic [1:0]  rdy, vld, er;
   logic [31:0] rd0, rd1;
   logic        cur_rdy, cur_vld, cur_er;
   logic [31:0] cur_rd;
   logic [31:0] mem_m [2][DEPTH];
   int          waitc [2] = '{1, 0};
   int          checks = 0, failures = 0;
   int          n;
   logic [31:0] a, r;

   always #5 clk = ~clk;

   assign cur_rdy = rdy[sel];
   assign cur_vld = vld[sel];
   assign cur_er  = er[sel];
   assign cur_rd  = sel == 1 ? rd1 : rd0;

   dm_responder #(.WAIT_CYCLES(1)) dut0 (
      .clk(clk), .reset(reset), .req_valid(req_valid && sel == 0), .req_ready(rdy[0]),
      .req_we(req_we), .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata), .req_pc(req_pc),
      .rsp_valid(vld[0]), .rsp_ready(rsp_ready && sel == 0), .rsp_rdata(rd0), .rsp_err(er[0])
   );
   dm_responder #(.WAIT_CYCLES(0)) dut1 (
      .clk(clk), .reset(reset), .req_valid(req_valid && sel == 1), .req_ready(rdy[1]),
      .req_we(req_we), .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata), .req_pc(req_pc),
      .rsp_valid(vld[1]), .rsp_ready(rsp_ready && sel == 1), .rsp_rdata(rd1), .rsp_err(er[1])
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic clear_model();
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < DEPTH; i++) mem_m[s][i] = '0;
   endtask

   task automatic wait_init();
      int k;
      k = 0;
      while (!rdy[0] && k < 3000) begin
         k++;
         @(negedge clk);
      end
      chk("init_cycles", k, 1024);
   endtask

   task automatic xact(input logic we, input logic [31:0] ad, input logic [3:0] be, input logic [31:0] wd,
                       input int hold, output logic [31:0] got);
      logic [31:0] exp_d;
      logic        exp_e;
      int          idx, k;
      exp_e = (ad % 4 != 0) || (ad / 4 >= DEPTH);
      idx   = int'(ad >> 2);
      exp_d = '0;
      if (!exp_e && we)
         for (int i = 0; i < 4; i++)
            if (be[i]) mem_m[sel][idx][8*i +: 8] = wd[8*i +: 8];
      if (!exp_e && !we) exp_d = mem_m[sel][idx];
      k = 0;
      while (!cur_rdy && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk("req_ready", cur_rdy, 1);
      req_valid = 1; req_we = we; req_addr = ad; req_be = be; req_wdata = wd; req_pc = $urandom;
      @(negedge clk);
      req_valid = 0; req_we = 1'($urandom); req_addr = $urandom; req_be = 4'($urandom); req_wdata = $urandom;
      k = 1;
      while (!cur_vld && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("latency", k, waitc[sel] + 2);
      chk("rdata", cur_rd, exp_d);
      chk("err", cur_er, exp_e);
      got = cur_rd;
      repeat (hold) begin
         @(negedge clk);
         chk("hold_valid", cur_vld, 1);
         chk("hold_rdata", cur_rd, exp_d);
         chk("hold_busy", cur_rdy, 0);
      end
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
      chk("valid_drop", cur_vld, 0);
      chk("back_idle", cur_rdy, 1);
   endtask

   task automatic rand_xact();
      logic [3:0] be;
      int         p;
      a = ($urandom % 16) * 4;
      p = $urandom % 8;
      if (p == 0) a = a + 1 + $urandom % 3;
      if (p == 1) a = 32'h1000 + ($urandom % 64) * 4;
      p = $urandom % 4;
      be = p == 0 ? BE_WORD : p == 1 ? BE_HALF_LO : p == 2 ? BE_HALF_HI : 4'($urandom);
      xact(1'($urandom), a, be, $urandom, $urandom % 3, r);
   endtask

   initial begin
      #200_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      clear_model();
      #1 reset = 0;
      repeat (3) @(negedge clk);
      chk("rst_ready", rdy[0], 0);
      chk("rst_valid", vld[0], 0);
      chk("rst_rdata", rd0, 0);
      chk("rst_err", er[0], 0);
      reset = 1;
      wait_init();
      sel = 0;
      xact(0, 32'h40, BE_WORD, 0, 0, r);                  chk("t1_load0", r, 0);
      xact(1, 32'h10, BE_WORD, 32'h1234_5678, 0, r);
      xact(0, 32'h10, BE_WORD, 0, 0, r);                  chk("t2_word", r, 32'h1234_5678);
      xact(1, 32'h10, BE_HALF_LO, 32'hAABB_CCDD, 0, r);
      xact(0, 32'h10, BE_WORD, 0, 0, r);                  chk("t3_half", r, 32'h1234_CCDD);
      xact(1, 32'h10, 4'b0000, 32'hFFFF_FFFF, 0, r);
      xact(0, 32'h10, BE_WORD, 0, 0, r);                  chk("t3_be0", r, 32'h1234_CCDD);
      xact(0, 32'h13, BE_WORD, 0, 0, r);                  chk("t4_mis_rdata", r, 0);
      xact(1, 32'h13, BE_WORD, 32'hDEAD_BEEF, 0, r);
      xact(0, 32'h1000, BE_WORD, 0, 0, r);                chk("t4_oor_rdata", r, 0);
      xact(1, 32'h1000, BE_WORD, 32'hCAFE_F00D, 0, r);
      xact(0, 32'h10, BE_WORD, 0, 0, r);                  chk("t4_nowrite", r, 32'h1234_CCDD);
      xact(0, 32'h0, BE_WORD, 0, 0, r);                   chk("t4_nowrap", r, 0);
      xact(0, 32'h10, BE_WORD, 0, 5, r);                  chk("t5_stall", r, 32'h1234_CCDD);
      repeat (40) rand_xact();
      n = 0;
      while (!rdy[0] && n < 100) begin
         @(negedge clk);
         n++;
      end
      req_valid = 1; req_we = 1; req_addr = 32'h20; req_be = BE_WORD; req_wdata = 32'h5555_AAAA;
      @(negedge clk);
      req_valid = 0;
      chk("t6_in_wait", rdy[0], 0);
      reset = 0;
      @(negedge clk);
      reset = 1;
      clear_model();
      wait_init();
      xact(0, 32'h20, BE_WORD, 0, 0, r);                  chk("t6_cleared", r, 0);
      xact(0, 32'h10, BE_WORD, 0, 0, r);                  chk("t6_recleared", r, 0);
      sel = 1;
      xact(1, 32'h8, BE_HALF_HI, 32'h9876_5432, 0, r);
      xact(0, 32'h8, BE_WORD, 0, 0, r);                   chk("w0_load", r, 32'h9876_0000);
      repeat (25) rand_xact();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
